ghost_mode_scheduler: RTL and testbench

Frame-rate mode sequencer that drives the global behaviour inputs of every ghost controller (`chase`, `scared_mode`, `scared_mode_end`). It runs the scatter/chase phase schedule, the power-pellet fright timer with its end-of-fright blink window, and a one-cycle reverse pulse at every phase change. It sits between the game-logic block (pellet and death events) and the four ghost controllers, and is driven by the same `vsync_enable` frame tick.

---
 rtl/ghost_mode_scheduler_if.sv | 25 ++
 rtl/ghost_mode_scheduler.sv | 98 +++++++++
 tb/tb_ghost_mode_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ghost_mode_scheduler_if.sv
// Signal bundle between game logic, the mode scheduler and the ghost controllers.
// No valid/ready handshake: inputs are levels or one-cycle pulses sampled on every clk edge.
interface ghost_mode_scheduler_if;
  logic       vsync_enable;
  logic       pause;
  logic       stall;
  logic       power_pellet;
  logic       pacman_dead;
  logic       end_of_game;
  logic       chase;
  logic       scared_mode;
  logic       scared_mode_end;
  logic       ghost_reverse;
  logic [2:0] phase;

  modport master (
    output vsync_enable, pause, stall, power_pellet, pacman_dead, end_of_game,
    input  chase, scared_mode, scared_mode_end, ghost_reverse, phase
  );

  modport slave (
    input  vsync_enable, pause, stall, power_pellet, pacman_dead, end_of_game,
    output chase, scared_mode, scared_mode_end, ghost_reverse, phase
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Scatter/chase phase schedule, fright timer with end-of-fright blink window,
// and one-cycle ghost reverse pulses. All outputs registered.
module ghost_mode_scheduler #(
  parameter int SCATTER_FRAMES    = 420,
  parameter int CHASE_FRAMES      = 1200,
  parameter int NUM_TIMED         = 7,
  parameter int SCARED_FRAMES     = 360,
  parameter int SCARED_END_FRAMES = 120,
  parameter int CNT_W             = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  ghost_mode_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] SCATTER_LAST = CNT_W'(SCATTER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CHASE_LAST   = CNT_W'(CHASE_FRAMES - 1);
  localparam logic [CNT_W-1:0] SCARED_LAST  = CNT_W'(SCARED_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_START  = CNT_W'(SCARED_FRAMES - SCARED_END_FRAMES);
  localparam logic [2:0]       LAST_PHASE   = 3'(NUM_TIMED);

  logic [2:0]       r_phase;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_scared_cnt;
  logic             r_scared;
  logic             r_scared_end;
  logic             r_chase;
  logic             r_reverse;

  logic             w_tick;
  logic             w_clear;
  logic [CNT_W-1:0] w_phase_last;
  logic             w_phase_timed;
  logic             w_phase_exp;
  logic             w_scared_exp;
  logic [2:0]       w_phase_nxt;
  logic [CNT_W-1:0] w_scared_inc;

  assign w_tick        = bus.vsync_enable & ~(bus.pause | bus.stall);
  assign w_clear       = bus.pacman_dead | bus.end_of_game;
  assign w_phase_last  = r_phase[0] ? CHASE_LAST : SCATTER_LAST;
  assign w_phase_timed = (r_phase < LAST_PHASE);
  assign w_phase_exp   = w_tick & ~r_scared & w_phase_timed & (r_phase_cnt == w_phase_last);
  assign w_scared_exp  = w_tick & r_scared & (r_scared_cnt == SCARED_LAST);
  assign w_phase_nxt   = r_phase + 3'd1;
  assign w_scared_inc  = r_scared_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase      <= '0;
      r_phase_cnt  <= '0;
      r_scared_cnt <= '0;
      r_scared     <= 1'b0;
      r_scared_end <= 1'b0;
      r_chase      <= 1'b1;
      r_reverse    <= 1'b0;
    end else if (w_clear) begin
      r_phase      <= '0;
      r_phase_cnt  <= '0;
      r_scared_cnt <= '0;
      r_scared     <= 1'b0;
      r_scared_end <= 1'b0;
      r_chase      <= 1'b1;
      r_reverse    <= 1'b0;
    end else if (bus.power_pellet) begin
      // Pellet beats any expiry this cycle; the phase timer is frozen from now on.
      r_scared     <= 1'b1;
      r_scared_cnt <= '0;
      r_scared_end <= (BLINK_START == '0);
      r_reverse    <= ~r_scared;
    end else begin
      r_reverse <= w_phase_exp;
      if (r_scared) begin
        if (w_scared_exp) begin
          r_scared     <= 1'b0;
          r_scared_cnt <= '0;
          r_scared_end <= 1'b0;
        end else if (w_tick) begin
          r_scared_cnt <= w_scared_inc;
          r_scared_end <= (w_scared_inc >= BLINK_START);
        end
      end else if (w_phase_exp) begin
        r_phase     <= w_phase_nxt;
        r_phase_cnt <= '0;
        r_chase     <= ~w_phase_nxt[0] & (w_phase_nxt != LAST_PHASE);
      end else if (w_tick && w_phase_timed) begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end
    end
  end

  assign bus.phase           = r_phase;
  assign bus.chase           = r_chase;
  assign bus.scared_mode     = r_scared;
  assign bus.scared_mode_end = r_scared_end;
  assign bus.ghost_reverse   = r_reverse;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with a small schedule
// (scatter 4, chase 6, 3 timed phases, fright 5 with 2-frame blink).
module tb_ghost_mode_scheduler;

  localparam int SCATTER_FRAMES    = 4;
  localparam int CHASE_FRAMES      = 6;
  localparam int NUM_TIMED         = 3;
  localparam int SCARED_FRAMES     = 5;
  localparam int SCARED_END_FRAMES = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ghost_mode_scheduler_if bus ();

  ghost_mode_scheduler #(
    .SCATTER_FRAMES   (SCATTER_FRAMES),
    .CHASE_FRAMES     (CHASE_FRAMES),
    .NUM_TIMED        (NUM_TIMED),
    .SCARED_FRAMES    (SCARED_FRAMES),
    .SCARED_END_FRAMES(SCARED_END_FRAMES),
    .CNT_W            (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rev_seen = 0;
  logic [2:0] exp_q[$];

  always @(negedge clk) if (bus.ghost_reverse === 1'b1) rev_seen++;

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // drivers
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic step(input logic v, input logic pel);
    bus.vsync_enable = v;
    bus.power_pellet = pel;
    @(posedge clk);
    #1;
    bus.vsync_enable = 1'b0;
    bus.power_pellet = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_phase"},  32'(bus.phase), 0);
    check({tag, "_chase"},  32'(bus.chase), 1);
    check({tag, "_scared"}, 32'(bus.scared_mode), 0);
    check({tag, "_end"},    32'(bus.scared_mode_end), 0);
    check({tag, "_rev"},    32'(bus.ghost_reverse), 0);
  endtask

  initial begin
    int base;
    logic [2:0] ep;
    bus.vsync_enable = 1'b0;
    bus.pause        = 1'b0;
    bus.stall        = 1'b0;
    bus.power_pellet = 1'b0;
    bus.pacman_dead  = 1'b0;
    bus.end_of_game  = 1'b0;

    // 1. full schedule
    do_reset();
    check_idle("reset");
    for (int t = 1; t <= 30; t++)
      exp_q.push_back((t < 4) ? 3'd0 : (t < 10) ? 3'd1 : (t < 14) ? 3'd2 : 3'd3);
    base = rev_seen;
    for (int t = 1; t <= 30; t++) begin
      step(1'b1, 1'b0);
      ep = exp_q.pop_front();
      check($sformatf("sched_phase_t%0d", t), 32'(bus.phase), 32'(ep));
      check($sformatf("sched_chase_t%0d", t), 32'(bus.chase), (ep == 3'd0 || ep == 3'd2) ? 1 : 0);
      check($sformatf("sched_rev_t%0d", t), 32'(bus.ghost_reverse),
            (t == 4 || t == 10 || t == 14) ? 1 : 0);
    end
    check("sched_rev_total", 32'(rev_seen - base), 3);

    // 2. fright with blink
    do_reset();
    ticks(2);
    step(1'b0, 1'b1);
    check("fright_on", 32'(bus.scared_mode), 1);
    check("fright_end0", 32'(bus.scared_mode_end), 0);
    check("fright_rev", 32'(bus.ghost_reverse), 1);
    for (int t = 1; t <= 5; t++) begin
      step(1'b1, 1'b0);
      check($sformatf("fright_scared_t%0d", t), 32'(bus.scared_mode), (t < 5) ? 1 : 0);
      check($sformatf("fright_end_t%0d", t), 32'(bus.scared_mode_end), (t >= 3 && t < 5) ? 1 : 0);
      check($sformatf("fright_rev_t%0d", t), 32'(bus.ghost_reverse), 0);
      check($sformatf("fright_phase_t%0d", t), 32'(bus.phase), 0);
    end
    step(1'b1, 1'b0);
    check("resume_phase_hold", 32'(bus.phase), 0);
    step(1'b1, 1'b0);
    check("resume_phase_adv", 32'(bus.phase), 1);
    check("resume_rev", 32'(bus.ghost_reverse), 1);

    // 3. pellet restart
    do_reset();
    step(1'b0, 1'b1);
    ticks(4);
    check("restart_end_before", 32'(bus.scared_mode_end), 1);
    base = rev_seen;
    step(1'b0, 1'b1);
    check("restart_end_drop", 32'(bus.scared_mode_end), 0);
    check("restart_scared", 32'(bus.scared_mode), 1);
    check("restart_no_rev", 32'(bus.ghost_reverse), 0);
    for (int t = 1; t <= 5; t++) begin
      step(1'b1, 1'b0);
      check($sformatf("restart_scared_t%0d", t), 32'(bus.scared_mode), (t < 5) ? 1 : 0);
    end
    check("restart_rev_total", 32'(rev_seen - base), 0);
    check("restart_phase", 32'(bus.phase), 0);

    // 4. pause / stall freeze
    do_reset();
    ticks(2);
    base = rev_seen;
    bus.pause = 1'b1;
    ticks(10);
    check_idle("pause");
    check("pause_rev_total", 32'(rev_seen - base), 0);
    step(1'b0, 1'b1);
    check("pause_pellet_scared", 32'(bus.scared_mode), 1);
    check("pause_pellet_rev", 32'(bus.ghost_reverse), 1);
    bus.pause = 1'b0;
    bus.stall = 1'b1;
    ticks(3);
    check("stall_end", 32'(bus.scared_mode_end), 0);
    bus.stall = 1'b0;
    ticks(4);
    check("unfreeze_scared", 32'(bus.scared_mode), 1);
    check("unfreeze_end", 32'(bus.scared_mode_end), 1);
    step(1'b1, 1'b0);
    check("unfreeze_fright_done", 32'(bus.scared_mode), 0);
    step(1'b1, 1'b0);
    check("unfreeze_phase_hold", 32'(bus.phase), 0);
    step(1'b1, 1'b0);
    check("unfreeze_phase_adv", 32'(bus.phase), 1);

    // 5. death clear
    do_reset();
    ticks(10);
    check("death_pre_phase", 32'(bus.phase), 2);
    step(1'b0, 1'b1);
    ticks(2);
    check("death_pre_scared", 32'(bus.scared_mode), 1);
    bus.pacman_dead = 1'b1;
    step(1'b0, 1'b0);
    check_idle("death");
    step(1'b1, 1'b0);
    check("death_held_phase", 32'(bus.phase), 0);
    bus.pacman_dead = 1'b0;
    ticks(10);
    check("eog_pre_phase", 32'(bus.phase), 2);
    bus.end_of_game = 1'b1;
    step(1'b0, 1'b1);
    check_idle("eog_pellet");
    bus.end_of_game = 1'b0;
    ticks(3);
    check("post_clear_phase3", 32'(bus.phase), 0);
    step(1'b1, 1'b0);
    check("post_clear_phase4", 32'(bus.phase), 1);

    // 6. asynchronous reset between edges
    do_reset();
    ticks(5);
    step(1'b0, 1'b1);
    ticks(3);
    check("areset_pre_phase", 32'(bus.phase), 1);
    check("areset_pre_end", 32'(bus.scared_mode_end), 1);
    #3 reset = 1'b0;
    #1;
    check_idle("areset");
    @(posedge clk);
    #1 reset = 1'b1;
    ticks(3);
    check("areset_after3", 32'(bus.phase), 0);
    step(1'b1, 1'b0);
    check("areset_after4", 32'(bus.phase), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
